// File: rtl/hpdcache_sram_wmask_1rw_ctrl.sv
// Controller for a single-port bit-masked SRAM: zero-fill after reset or clear,
// then round-robin sharing of the port between one reader and one writer.
// Read responses use a valid/ready handshake backed by a hold register.
module hpdcache_sram_wmask_1rw_ctrl #(
    parameter int unsigned ADDR_SIZE = 3,
    parameter int unsigned DATA_SIZE = 16,
    parameter int unsigned DEPTH     = 2**ADDR_SIZE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    output logic                 init_done,

    input  logic                 rd_req_valid,
    output logic                 rd_req_ready,
    input  logic [ADDR_SIZE-1:0] rd_req_addr,
    output logic                 rd_rsp_valid,
    input  logic                 rd_rsp_ready,
    output logic [DATA_SIZE-1:0] rd_rsp_data,

    input  logic                 wr_req_valid,
    output logic                 wr_req_ready,
    input  logic [ADDR_SIZE-1:0] wr_req_addr,
    input  logic [DATA_SIZE-1:0] wr_req_data,
    input  logic [DATA_SIZE-1:0] wr_req_mask,

    output logic                 sram_cs,
    output logic                 sram_we,
    output logic [ADDR_SIZE-1:0] sram_addr,
    output logic [DATA_SIZE-1:0] sram_wdata,
    output logic [DATA_SIZE-1:0] sram_wmask,
    input  logic [DATA_SIZE-1:0] sram_rdata
);

    typedef enum logic {ST_INIT, ST_RUN} state_e;
    typedef enum logic {RR_RD, RR_WR} rr_e;

    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(DEPTH - 1);

    state_e                 state_q, state_d;
    rr_e                    rr_q, rr_d;
    logic [ADDR_SIZE-1:0]   cnt_q, cnt_d;

    logic                   rd_elig, wr_elig;
    logic                   rd_grant, wr_grant;

    logic                   rsp_valid_q;
    logic                   use_hold_q;
    logic [DATA_SIZE-1:0]   hold_q;

    // State, fill counter and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            rr_q    <= RR_RD;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
        end
    end

    // Next state, arbitration and SRAM port drive
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rr_d         = rr_q;
        init_done    = 1'b0;
        rd_req_ready = 1'b0;
        wr_req_ready = 1'b0;
        rd_elig      = 1'b0;
        wr_elig      = 1'b0;
        rd_grant     = 1'b0;
        wr_grant     = 1'b0;
        sram_cs      = 1'b0;
        sram_we      = 1'b0;
        sram_addr    = '0;
        sram_wdata   = '0;
        sram_wmask   = '0;

        case (state_q)
            ST_INIT: begin
                sram_cs    = 1'b1;
                sram_we    = 1'b1;
                sram_addr  = cnt_q;
                sram_wmask = '1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_SIZE'(1);
                end
            end

            ST_RUN: begin
                init_done = 1'b1;
                // A read may only go when its response slot is free or freeing now
                rd_elig   = rd_req_valid && (!rsp_valid_q || rd_rsp_ready);
                wr_elig   = wr_req_valid;
                rd_grant  = rd_elig && (!wr_elig || (rr_q == RR_RD));
                wr_grant  = wr_elig && !rd_grant;
                if (rd_elig && wr_elig) begin
                    rr_d = (rr_q == RR_RD) ? RR_WR : RR_RD;
                end
                rd_req_ready = rd_grant;
                wr_req_ready = wr_grant;
                if (rd_grant) begin
                    sram_cs   = 1'b1;
                    sram_addr = rd_req_addr;
                end else if (wr_grant) begin
                    sram_cs    = 1'b1;
                    sram_we    = 1'b1;
                    sram_addr  = wr_req_addr;
                    sram_wdata = wr_req_data;
                    sram_wmask = wr_req_mask;
                end
                if (clear) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end
            end

            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    // Read response tracking; data is frozen in hold_q after the bypass cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            use_hold_q  <= 1'b0;
            hold_q      <= '0;
        end else begin
            if (rd_grant) begin
                rsp_valid_q <= 1'b1;
                use_hold_q  <= 1'b0;
            end else if (rsp_valid_q && rd_rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end else if (rsp_valid_q) begin
                use_hold_q <= 1'b1;
            end
            if (rsp_valid_q && !use_hold_q) begin
                hold_q <= sram_rdata;
            end
        end
    end

    assign rd_rsp_valid = rsp_valid_q;
    assign rd_rsp_data  = (rsp_valid_q && !use_hold_q) ? sram_rdata : hold_q;

endmodule

// File: tb/tb_hpdcache_sram_wmask_1rw_ctrl.sv
// Scoreboard bench for hpdcache_sram_wmask_1rw_ctrl with a behavioural SRAM.
module tb_hpdcache_sram_wmask_1rw_ctrl;

    localparam int unsigned AW = 3;
    localparam int unsigned DW = 16;
    localparam int unsigned DP = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear;
    logic          init_done;
    logic          rd_req_valid, rd_req_ready;
    logic [AW-1:0] rd_req_addr;
    logic          rd_rsp_valid, rd_rsp_ready;
    logic [DW-1:0] rd_rsp_data;
    logic          wr_req_valid, wr_req_ready;
    logic [AW-1:0] wr_req_addr;
    logic [DW-1:0] wr_req_data, wr_req_mask;
    logic          sram_cs, sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata, sram_wmask;
    logic [DW-1:0] sram_rdata = 16'hBAD0;

    logic [DW-1:0] mem [DP] = '{default: 16'hDEAD};

    int n_vec = 0;
    int n_err = 0;
    logic [DW-1:0] exp_q[$];

    hpdcache_sram_wmask_1rw_ctrl #(
        .ADDR_SIZE(AW), .DATA_SIZE(DW), .DEPTH(DP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .init_done(init_done),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_ready(rd_rsp_ready), .rd_rsp_data(rd_rsp_data),
        .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready), .wr_req_addr(wr_req_addr),
        .wr_req_data(wr_req_data), .wr_req_mask(wr_req_mask),
        .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_wmask(sram_wmask), .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    // SRAM macro model: 1-cycle read latency, read data garbage after a write
    always @(posedge clk) begin
        if (sram_cs) begin
            if (sram_we) begin
                mem[sram_addr] <= (mem[sram_addr] & ~sram_wmask) | (sram_wdata & sram_wmask);
                sram_rdata     <= 16'hBAD0;
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare each accepted read response against the scoreboard
    always @(negedge clk) begin
        if (rst_n && rd_rsp_valid && rd_rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 32'(rd_rsp_data), 32'hFFFF_FFFF);
            end else begin
                check("rsp_data", 32'(rd_rsp_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic init_seq(input string tag);
        for (int i = 0; i < int'(DP); i++) begin
            @(negedge clk);
            check({tag, "_addr"}, 32'(sram_addr), 32'(i));
            check({tag, "_ctl"}, {27'd0, sram_cs, sram_we, init_done, rd_req_ready, wr_req_ready},
                  32'b11000);
            check({tag, "_data"}, {sram_wdata, sram_wmask}, 32'h0000_FFFF);
            @(posedge clk);
        end
        #1;
        check({tag, "_done"}, 32'(init_done), 32'd1);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] e);
        bit got;
        got = 1'b0;
        rd_req_valid = 1'b1;
        rd_req_addr  = a;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            if (rd_req_ready) begin
                exp_q.push_back(e);
                got = 1'b1;
            end
        end
        check("rd_grant", 32'(got), 32'd1);
        tick();
        rd_req_valid = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] m);
        bit got;
        got = 1'b0;
        wr_req_valid = 1'b1;
        wr_req_addr  = a;
        wr_req_data  = d;
        wr_req_mask  = m;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            if (wr_req_ready) got = 1'b1;
        end
        check("wr_grant", 32'(got), 32'd1);
        tick();
        wr_req_valid = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        clear        = 1'b0;
        rd_req_valid = 1'b0;
        rd_req_addr  = '0;
        rd_rsp_ready = 1'b1;
        wr_req_valid = 1'b0;
        wr_req_addr  = '0;
        wr_req_data  = '0;
        wr_req_mask  = '0;

        // Reset values
        tick();
        check("rst_ctl", {27'd0, init_done, rd_req_ready, wr_req_ready, rd_rsp_valid, 1'b0}, 32'd0);
        check("rst_rsp_data", 32'(rd_rsp_data), 32'd0);
        check("rst_sram", {26'd0, sram_cs, sram_we, 1'b0, sram_addr}, 32'b11_0_000);
        check("rst_sram_data", {sram_wdata, sram_wmask}, 32'h0000_FFFF);
        tick();
        rst_n = 1'b1;
        init_seq("init");

        // Every location reads back zero after the fill
        for (int a = 0; a < int'(DP); a++) do_read(AW'(a), 16'h0000);

        // Masked write then read
        do_write(3'd3, 16'hA5A5, 16'h00FF);
        do_read(3'd3, 16'h00A5);
        check("rd_latency", 32'(rd_rsp_valid), 32'd1);

        // Round-robin alternation under continuous contention
        rd_req_valid = 1'b1;
        rd_req_addr  = 3'd5;
        wr_req_valid = 1'b1;
        wr_req_addr  = 3'd4;
        wr_req_data  = 16'h1234;
        wr_req_mask  = 16'hFFFF;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("arb", {30'd0, rd_req_ready, wr_req_ready}, (i % 2 == 0) ? 32'b10 : 32'b01);
            if (rd_req_ready) exp_q.push_back(16'h0000);
            @(posedge clk);
        end
        #1;
        rd_req_valid = 1'b0;
        wr_req_valid = 1'b0;

        // Held response stays stable while writes reuse the port
        do_write(3'd1, 16'h0011, 16'hFFFF);
        rd_rsp_ready = 1'b0;
        do_read(3'd1, 16'h0011);
        rd_req_valid = 1'b1;
        rd_req_addr  = 3'd1;
        wr_req_valid = 1'b1;
        wr_req_addr  = 3'd1;
        wr_req_data  = 16'h0022;
        wr_req_mask  = 16'hFFFF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("hold_data", 32'(rd_rsp_data), 32'h0011);
            check("hold_ctl", {29'd0, rd_rsp_valid, rd_req_ready, wr_req_ready}, 32'b101);
            @(posedge clk);
        end
        #1;
        rd_rsp_ready = 1'b1;
        @(negedge clk);
        check("hold_release", {30'd0, rd_req_ready, wr_req_ready}, 32'b10);
        if (rd_req_ready) exp_q.push_back(16'h0022);
        tick();
        rd_req_valid = 1'b0;
        wr_req_valid = 1'b0;

        // Clear with a pending response
        do_write(3'd6, 16'h6666, 16'hFFFF);
        rd_rsp_ready = 1'b0;
        do_read(3'd6, 16'h6666);
        clear = 1'b1;
        tick();
        clear        = 1'b0;
        check("clr_pending", {30'd0, rd_rsp_valid, init_done}, 32'b10);
        rd_rsp_ready = 1'b1;
        init_seq("clr_init");
        do_read(3'd6, 16'h0000);
        do_read(3'd3, 16'h0000);

        // Reset in the middle of a fill
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < 5; i++) @(posedge clk);
        @(negedge clk);
        check("mid_init_addr", 32'(sram_addr), 32'd5);
        rst_n = 1'b0;
        #1;
        check("mid_rst_addr", {28'd0, init_done, sram_addr}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        init_seq("rst_init");
        do_read(3'd1, 16'h0000);

        repeat (3) @(posedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
